alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU operand/opcode interface: accepts one operation request from the control unit,

---
 rtl/alu_ops_pkg.sv | 41 ++++
 rtl/alu_lat_counter.sv | 27 ++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Shared opcode encoding, FSM state type and default latencies for the ALU operand sequencer.
package alu_ops_pkg;

  typedef enum logic [4:0] {
    OP_AND  = 5'd0,
    OP_OR   = 5'd1,
    OP_NOT  = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_MUL  = 5'd5,
    OP_DIV  = 5'd6,
    OP_SHL  = 5'd7,
    OP_SHR  = 5'd8,
    OP_SHRA = 5'd9,
    OP_ROL  = 5'd10,
    OP_ROR  = 5'd11,
    OP_NEG  = 5'd12
  } alu_op_e;

  localparam logic [4:0] OP_LAST = 5'd12;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DIV_CYCLES = 33;
  localparam int DEF_OP_CYCLES  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } seq_state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_LAST;
  endfunction

  // MUL and DIV produce a meaningful upper half; everything else is a DATA_W result.
  function automatic logic op_wide(input logic [4:0] op);
    return (op == 5'(OP_MUL)) || (op == 5'(OP_DIV));
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Latency down-counter: loads L-1 on issue, decrements while enabled, saturates at zero.
module alu_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one opcode/operand set to the ALU, waits its latency, returns the 64-bit result.
// Optional flag_z/flag_n outputs are built when ALU_SEQ_FLAGS_EN is defined.
module alu_op_sequencer
  import alu_ops_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int OP_CYCLES  = DEF_OP_CYCLES
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [4:0]          alu_signal,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                flag_z,
  output logic                flag_n,
`endif
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo
);

  localparam int MAX_LAT = (DIV_CYCLES > OP_CYCLES) ? DIV_CYCLES : OP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] OP_LOAD  = CNT_W'(OP_CYCLES - 1);

  seq_state_t       state;
  logic             cnt_load;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_init;

  assign req_ready = (state == ST_IDLE) && !clear;
  assign cnt_load  = req_valid && req_ready && op_legal(req_op);
  assign cnt_init  = (req_op == 5'(OP_DIV)) ? DIV_LOAD : OP_LOAD;

  alu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat (
    .clk      (clk),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (cnt_init),
    .dec      (state == ST_BUSY),
    .zero     (cnt_zero)
  );

`ifdef ALU_SEQ_FLAGS_EN
  function automatic logic zero_flag(input logic [4:0] op, input logic [2*DATA_W-1:0] res);
    return op_wide(op) ? (res == '0) : (res[DATA_W-1:0] == '0);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_IDLE;
      alu_signal <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      z_hi       <= '0;
      z_lo       <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (op_legal(req_op)) begin
              alu_signal <= req_op;
              alu_a      <= req_a;
              alu_b      <= req_b;
              state      <= ST_BUSY;
            end else begin
              // Illegal opcode: ALU inputs and Z keep their previous values.
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_zero) begin
            z_hi      <= alu_result[2*DATA_W-1:DATA_W];
            z_lo      <= alu_result[DATA_W-1:0];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z    <= zero_flag(alu_signal, alu_result);
            flag_n    <= alu_result[DATA_W-1];
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a transaction-level model checked every cycle.
module tb_alu_op_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clear, req_valid, rsp_ready;
  logic [4:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          req_ready, rsp_valid, rsp_err;
  logic [4:0]    alu_signal;
  logic [DW-1:0] alu_a, alu_b, z_hi, z_lo;
  logic [2*DW-1:0] alu_result;
`ifdef ALU_SEQ_FLAGS_EN
  logic          flag_z, flag_n;
`endif

  int checks = 0;
  int errors = 0;

  // Expected-state model: what the response side must show, driven by request/response rules.
  logic          m_busy = 1'b0, m_resp = 1'b0, m_err = 1'b0;
  logic [4:0]    m_sig = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_zhi = '0, m_zlo = '0;
  logic [63:0]   m_res = '0;
  logic          m_fz = 1'b0, m_fn = 1'b0;
  int            m_left = 0;

  always #5 clk = ~clk;

  // Reference ALU: answers whatever the sequencer currently drives.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    logic [63:0] p;
    logic [4:0]  s;
    sa = a; sb = b; s = b[4:0];
    case (op)
      5'd0:  return {32'd0, a & b};
      5'd1:  return {32'd0, a | b};
      5'd2:  return {32'd0, ~a};
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p;
      end
      5'd6: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      5'd7:  return {32'd0, a << s};
      5'd8:  return {32'd0, a >> s};
      5'd9:  return {32'd0, 32'(sa >>> s)};
      5'd10: return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
      5'd11: return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
      5'd12: return {32'd0, -a};
      default: return 64'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_signal, alu_a, alu_b);

  alu_op_sequencer dut (
    .clk        (clk),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_signal (alu_signal),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_z     (flag_z),
    .flag_n     (flag_n),
`endif
    .z_hi       (z_hi),
    .z_lo       (z_lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_run();
    forever begin
      @(posedge clk);
      if (clear) begin
        m_busy = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_sig = '0;
        m_a = '0; m_b = '0; m_zhi = '0; m_zlo = '0; m_fz = 1'b0; m_fn = 1'b0;
      end else if (m_resp) begin
        if (rsp_ready) m_resp = 1'b0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_zhi = m_res[63:32]; m_zlo = m_res[31:0]; m_err = 1'b0;
          m_fz = (m_sig == 5'd5 || m_sig == 5'd6) ? (m_res == 64'd0) : (m_res[31:0] == 32'd0);
          m_fn = m_res[31];
          m_busy = 1'b0; m_resp = 1'b1;
        end
      end else if (req_valid) begin
        if (req_op > 5'd12) begin
          m_err = 1'b1; m_resp = 1'b1;
        end else begin
          m_sig = req_op; m_a = req_a; m_b = req_b;
          m_res = alu_fn(req_op, req_a, req_b);
          m_left = (req_op == 5'd6) ? 33 : 1;
          m_busy = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy && !m_resp && !clear});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_resp});
      chk("rsp_err", {63'd0, rsp_err}, {63'd0, m_err});
      chk("z_hi", {32'd0, z_hi}, {32'd0, m_zhi});
      chk("z_lo", {32'd0, z_lo}, {32'd0, m_zlo});
      chk("alu_signal", {59'd0, alu_signal}, {59'd0, m_sig});
      chk("alu_a", {32'd0, alu_a}, {32'd0, m_a});
      chk("alu_b", {32'd0, alu_b}, {32'd0, m_b});
`ifdef ALU_SEQ_FLAGS_EN
      chk("flag_z", {63'd0, flag_z}, {63'd0, m_fz});
      chk("flag_n", {63'd0, flag_n}, {63'd0, m_fn});
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one op with rsp_ready high, measure edges to rsp_valid, check literals, handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic eerr);
    int lat;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (!eerr) chk("lit alu_signal", {59'd0, alu_signal}, {59'd0, op});
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("lit latency", 64'(lat), 64'(exp_lat));
    chk("lit z_hi", {32'd0, z_hi}, {32'd0, ehi});
    chk("lit z_lo", {32'd0, z_lo}, {32'd0, elo});
    chk("lit rsp_err", {63'd0, rsp_err}, {63'd0, eerr});
    step();
    chk("lit ready after handshake", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    clear = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    fork model_run(); join_none
    step();
    step();
    fork monitor(); join_none
    chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset z_lo", {32'd0, z_lo}, 64'd0);
    chk("reset alu_a", {32'd0, alu_a}, 64'd0);
    chk("reset ready in clear", {63'd0, req_ready}, 64'd0);
    clear = 1'b0;
    #1;
    chk("reset ready after clear", {63'd0, req_ready}, 64'd1);
    step();

    run_op(5'd3, 32'd1, 32'd1, 1, 32'h0, 32'h2, 1'b0);                       // ADD
    run_op(5'd5, 32'd2, 32'd3, 1, 32'h0, 32'h6, 1'b0);                       // MUL
    run_op(5'd5, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);  // MUL signed
    run_op(5'd6, 32'hFFFFFFF0, 32'd16, 33, 32'h0, 32'hFFFFFFFF, 1'b0);       // DIV
    run_op(5'd31, 32'h1234, 32'h5678, 0, 32'h0, 32'hFFFFFFFF, 1'b1);         // illegal
    chk("lit illegal alu_signal", {59'd0, alu_signal}, 64'd6);
    chk("lit illegal alu_a", {32'd0, alu_a}, 64'hFFFFFFF0);
    chk("lit illegal alu_b", {32'd0, alu_b}, 64'd16);
    run_op(5'd13, 32'd7, 32'd7, 0, 32'h0, 32'hFFFFFFFF, 1'b1);               // first illegal
    run_op(5'd12, 32'd5, 32'd0, 1, 32'h0, 32'hFFFFFFFB, 1'b0);               // NEG, last legal
    run_op(5'd9, 32'h80000000, 32'd4, 1, 32'h0, 32'hF8000000, 1'b0);         // SHRA
    run_op(5'd11, 32'h00000001, 32'd1, 1, 32'h0, 32'h80000000, 1'b0);        // ROR
    run_op(5'd4, 32'd3, 32'd5, 1, 32'h0, 32'hFFFFFFFE, 1'b0);                // SUB

    // clear on the 10th BUSY edge of a DIV drops the op
    req_op = 5'd6; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("clr rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("clr z_hi", {32'd0, z_hi}, 64'd0);
    chk("clr z_lo", {32'd0, z_lo}, 64'd0);
    chk("clr alu_signal", {59'd0, alu_signal}, 64'd0);
    chk("clr alu_a", {32'd0, alu_a}, 64'd0);
    chk("clr alu_b", {32'd0, alu_b}, 64'd0);
    chk("clr rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("clr req_ready", {63'd0, req_ready}, 64'd1);
    repeat (40) begin
      step();
      chk("clr no rsp", {63'd0, rsp_valid}, 64'd0);
    end

    // SHL with back-pressure; a second request waits for the handshake
    rsp_ready = 1'b0;
    req_op = 5'd7; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
    step();
    req_op = 5'd3; req_a = 32'd5; req_b = 32'd5;
    step();
    chk("bp rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("bp z_lo", {32'd0, z_lo}, 64'd4);
    repeat (3) begin
      step();
      chk("bp held valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp held z_lo", {32'd0, z_lo}, 64'd4);
      chk("bp not ready", {63'd0, req_ready}, 64'd0);
      chk("bp alu_signal", {59'd0, alu_signal}, 64'd7);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp after hs ready", {63'd0, req_ready}, 64'd1);
    chk("bp after hs alu_signal", {59'd0, alu_signal}, 64'd7);
    step();
    req_valid = 1'b0;
    chk("bp second accept", {59'd0, alu_signal}, 64'd3);
    step();
    chk("bp second valid", {63'd0, rsp_valid}, 64'd1);
    chk("bp second z_lo", {32'd0, z_lo}, 64'd10);
    step();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
